// File: rtl/agc_level_monitor_if.sv
// Sample/result bundle between the AGC output stage and the level monitor.
// The master drives samples; the slave (the monitor) returns the window statistics.
interface agc_level_monitor_if #(
  parameter int DATA_W = 8
);
  logic              clk_enable;
  logic              clear;
  logic [DATA_W-1:0] In1;
  logic [DATA_W-1:0] peak_out;
  logic [DATA_W-1:0] mean_out;
  logic [7:0]        clip_count;
  logic              peak_valid;
  logic              win_active;

  modport master (
    output clk_enable, clear, In1,
    input  peak_out, mean_out, clip_count, peak_valid, win_active
  );

  modport slave (
    input  clk_enable, clear, In1,
    output peak_out, mean_out, clip_count, peak_valid, win_active
  );
endinterface

// File: rtl/agc_level_monitor.sv
// Windowed statistics on AGC output samples: peak |x|, mean |x| and clip count,
// published once per 2^WIN_LOG2 accepted samples.
module agc_level_monitor #(
  parameter int DATA_W      = 8,
  parameter int WIN_LOG2    = 8,
  parameter int CLIP_THRESH = 120
) (
  input logic                clk,
  input logic                reset,
  agc_level_monitor_if.slave bus
);
  localparam int            ACC_W  = DATA_W + WIN_LOG2;
  localparam [DATA_W-1:0]   CLIP_T = DATA_W'(CLIP_THRESH);

  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [DATA_W-1:0]   run_peak_q, run_peak_d;
  logic [7:0]          run_clip_q, run_clip_d;
  logic                win_active_q, win_active_d;
  logic [DATA_W-1:0]   peak_q, peak_d;
  logic [DATA_W-1:0]   mean_q, mean_d;
  logic [7:0]          clip_q, clip_d;
  logic                valid_q, valid_d;

  logic [DATA_W-1:0]   mag;
  logic [DATA_W-1:0]   peak_new;
  logic [ACC_W-1:0]    acc_new;
  logic [7:0]          clip_new;

  always_comb begin
    // Unsigned DATA_W-bit magnitude: the most negative input maps to 2^(DATA_W-1).
    mag = bus.In1;
    if (bus.In1[DATA_W-1]) mag = ~bus.In1 + 1'b1;

    peak_new = (mag > run_peak_q) ? mag : run_peak_q;
    acc_new  = acc_q + {{WIN_LOG2{1'b0}}, mag};
    clip_new = run_clip_q;
    if (mag >= CLIP_T && run_clip_q != 8'hFF) clip_new = run_clip_q + 8'd1;

    cnt_d        = cnt_q;
    acc_d        = acc_q;
    run_peak_d   = run_peak_q;
    run_clip_d   = run_clip_q;
    win_active_d = win_active_q;
    peak_d       = peak_q;
    mean_d       = mean_q;
    clip_d       = clip_q;
    valid_d      = 1'b0;

    if (bus.clear) begin
      cnt_d        = '0;
      acc_d        = '0;
      run_peak_d   = '0;
      run_clip_d   = '0;
      win_active_d = 1'b0;
    end else if (bus.clk_enable) begin
      if (&cnt_q) begin
        // Publish including the closing sample and restart in the same edge.
        peak_d       = peak_new;
        mean_d       = acc_new[ACC_W-1 -: DATA_W];
        clip_d       = clip_new;
        valid_d      = 1'b1;
        cnt_d        = '0;
        acc_d        = '0;
        run_peak_d   = '0;
        run_clip_d   = '0;
        win_active_d = 1'b0;
      end else begin
        cnt_d        = cnt_q + 1'b1;
        acc_d        = acc_new;
        run_peak_d   = peak_new;
        run_clip_d   = clip_new;
        win_active_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      acc_q        <= '0;
      run_peak_q   <= '0;
      run_clip_q   <= '0;
      win_active_q <= 1'b0;
      peak_q       <= '0;
      mean_q       <= '0;
      clip_q       <= '0;
      valid_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      run_peak_q   <= run_peak_d;
      run_clip_q   <= run_clip_d;
      win_active_q <= win_active_d;
      peak_q       <= peak_d;
      mean_q       <= mean_d;
      clip_q       <= clip_d;
      valid_q      <= valid_d;
    end
  end

  assign bus.peak_out   = peak_q;
  assign bus.mean_out   = mean_q;
  assign bus.clip_count = clip_q;
  assign bus.peak_valid = valid_q;
  assign bus.win_active = win_active_q;
endmodule

// File: tb/tb_agc_level_monitor.sv
// Bench for agc_level_monitor: a 4-sample window instance driven from a vector table
// and hand sequences, plus a 512-sample instance for clip saturation.
module tb_agc_level_monitor;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  agc_level_monitor_if #(.DATA_W(8)) b2 ();
  agc_level_monitor_if #(.DATA_W(8)) b9 ();

  agc_level_monitor #(.DATA_W(8), .WIN_LOG2(2), .CLIP_THRESH(120)) dut2 (
    .clk(clk), .reset(reset), .bus(b2)
  );
  agc_level_monitor #(.DATA_W(8), .WIN_LOG2(9), .CLIP_THRESH(120)) dut9 (
    .clk(clk), .reset(reset), .bus(b9)
  );

  typedef struct packed {
    logic [7:0] peak;
    logic [7:0] mean;
    logic [7:0] clip;
  } res_t;

  typedef struct packed {
    logic [3:0][7:0] s;
    res_t            exp;
  } vec_t;

  res_t q2[$];
  res_t q9[$];
  int   pulse_t2[$];
  logic prev2 = 1'b0;
  logic prev9 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic res_t mkr(input int p, input int m, input int c);
    res_t r;
    r.peak = 8'(p);
    r.mean = 8'(m);
    r.clip = 8'(c);
    return r;
  endfunction

  function automatic vec_t mkv(input int a, input int b, input int c, input int d,
                               input int p, input int m, input int k);
    vec_t v;
    v.s[0] = 8'(a);
    v.s[1] = 8'(b);
    v.s[2] = 8'(c);
    v.s[3] = 8'(d);
    v.exp  = mkr(p, m, k);
    return v;
  endfunction

  // Scoreboard: every publish pulse pops one expected window result.
  always @(negedge clk) begin
    if (!reset) begin
      if (b2.peak_valid) begin
        pulse_t2.push_back(cyc);
        if (prev2) chk("pulse2_width", 32'd2, 32'd1);
        if (q2.size() == 0) begin
          chk("unexpected_pulse2", 32'd1, 32'd0);
        end else begin
          res_t e;
          e = q2.pop_front();
          chk("peak2", b2.peak_out, e.peak);
          chk("mean2", b2.mean_out, e.mean);
          chk("clip2", b2.clip_count, e.clip);
        end
      end
      if (b9.peak_valid) begin
        if (prev9) chk("pulse9_width", 32'd2, 32'd1);
        if (q9.size() == 0) begin
          chk("unexpected_pulse9", 32'd1, 32'd0);
        end else begin
          res_t e;
          e = q9.pop_front();
          chk("peak9", b9.peak_out, e.peak);
          chk("mean9", b9.mean_out, e.mean);
          chk("clip9", b9.clip_count, e.clip);
        end
      end
    end
    prev2 <= b2.peak_valid;
    prev9 <= b9.peak_valid;
  end

  task automatic s2(input logic en, input logic clr, input int x);
    b2.clk_enable = en;
    b2.clear      = clr;
    b2.In1        = 8'(x);
    @(posedge clk); #1;
    b2.clk_enable = 1'b0;
    b2.clear      = 1'b0;
  endtask

  task automatic s9(input logic en, input int x);
    b9.clk_enable = en;
    b9.In1        = 8'(x);
    @(posedge clk); #1;
    b9.clk_enable = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) s2(1'b0, 1'b0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  vec_t tbl[7];

  initial begin
    tbl[0] = mkv(  10,  -20,    5, -128, 128,  40, 1);
    tbl[1] = mkv(  50,   50,   50,   50,  50,  50, 0);
    tbl[2] = mkv(  50,   50,   50,   50,  50,  50, 0);
    tbl[3] = mkv(  50,   50,   50,   50,  50,  50, 0);
    tbl[4] = mkv( 127, -127,    0,    1, 127,  63, 2);
    tbl[5] = mkv( 119,  120, -119, -120, 120, 119, 2);
    tbl[6] = mkv(  -1,    1,   -2,    2,   2,   1, 0);

    reset = 1'b1;
    b2.clk_enable = 1'b0; b2.clear = 1'b0; b2.In1 = '0;
    b9.clk_enable = 1'b0; b9.clear = 1'b0; b9.In1 = '0;
    #3;
    chk("rst_peak2", b2.peak_out, 0);
    chk("rst_mean2", b2.mean_out, 0);
    chk("rst_clip2", b2.clip_count, 0);
    chk("rst_valid2", b2.peak_valid, 0);
    chk("rst_active2", b2.win_active, 0);
    chk("rst_peak9", b9.peak_out, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);

    // Back-to-back windows, one strobe per cycle with no gaps.
    for (int v = 0; v < 7; v++) begin
      q2.push_back(tbl[v].exp);
      for (int k = 0; k < 4; k++) s2(1'b1, 1'b0, int'($signed(tbl[v].s[k])));
    end
    idle(3);
    chk("held_peak", b2.peak_out, 2);
    chk("held_mean", b2.mean_out, 1);
    chk("held_clip", b2.clip_count, 0);
    chk("pulse_count", pulse_t2.size(), 7);
    for (int i = 1; i < pulse_t2.size(); i++)
      chk("pulse_spacing", pulse_t2[i] - pulse_t2[i-1], 4);

    // Sparse strobes of zero: one accepted sample every three cycles.
    chk("sparse_idle_active", b2.win_active, 0);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) q2.push_back(mkr(0, 0, 0));
      s2(1'b1, 1'b0, 0);
      if (k == 0) chk("sparse_active_rise", b2.win_active, 1);
      if (k < 3) begin
        chk("sparse_hold_peak", b2.peak_out, 2);
        idle(2);
      end
    end
    chk("sparse_active_fall", b2.win_active, 0);
    chk("sparse_valid", b2.peak_valid, 1);
    idle(2);

    // Clear mid-window, with a strobe carrying 127 in the clear cycle.
    for (int k = 0; k < 3; k++) s2(1'b1, 1'b0, 127);
    chk("clr_active_before", b2.win_active, 1);
    s2(1'b1, 1'b1, 127);
    chk("clr_active_after", b2.win_active, 0);
    chk("clr_valid", b2.peak_valid, 0);
    q2.push_back(mkr(1, 1, 0));
    for (int k = 0; k < 4; k++) s2(1'b1, 1'b0, 1);
    idle(2);

    // Clear on the window-close cycle suppresses the publish.
    for (int k = 0; k < 3; k++) s2(1'b1, 1'b0, 5);
    s2(1'b1, 1'b1, 5);
    chk("clr_close_valid", b2.peak_valid, 0);
    chk("clr_close_peak", b2.peak_out, 1);
    q2.push_back(mkr(3, 3, 0));
    for (int k = 0; k < 4; k++) s2(1'b1, 1'b0, 3);
    idle(2);

    // 512-sample window of -128: clip count saturates.
    chk("w9_active_before", b9.win_active, 0);
    q9.push_back(mkr(128, 128, 255));
    for (int k = 0; k < 512; k++) s9(1'b1, -128);
    chk("w9_active_after", b9.win_active, 0);
    idle(2);

    // Asynchronous reset between edges mid-window.
    q2.push_back(mkr(50, 50, 0));
    for (int k = 0; k < 4; k++) s2(1'b1, 1'b0, 50);
    s2(1'b1, 1'b0, 7);
    s2(1'b1, 1'b0, 7);
    chk("pre_rst_peak", b2.peak_out, 50);
    chk("pre_rst_active", b2.win_active, 1);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("arst_peak2", b2.peak_out, 0);
    chk("arst_mean2", b2.mean_out, 0);
    chk("arst_clip2", b2.clip_count, 0);
    chk("arst_active2", b2.win_active, 0);
    chk("arst_peak9", b9.peak_out, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    q2.push_back(mkr(100, 30, 0));
    s2(1'b1, 1'b0, 9);
    s2(1'b1, 1'b0, -9);
    s2(1'b1, 1'b0, 100);
    s2(1'b1, 1'b0, 4);
    idle(3);

    chk("q2_drained", q2.size(), 0);
    chk("q9_drained", q9.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
